// File: rtl/decode_pkg.sv
// rtl/decode_pkg.sv - shared decode tables: ALU commands, ARM opcodes, modes, condition codes, control struct
package decode_pkg;

    localparam logic [3:0] EXE_MOV = 4'b0001;
    localparam logic [3:0] EXE_MVN = 4'b1001;
    localparam logic [3:0] EXE_ADD = 4'b0010;
    localparam logic [3:0] EXE_ADC = 4'b0011;
    localparam logic [3:0] EXE_SUB = 4'b0100;
    localparam logic [3:0] EXE_SBC = 4'b0101;
    localparam logic [3:0] EXE_AND = 4'b0110;
    localparam logic [3:0] EXE_ORR = 4'b0111;
    localparam logic [3:0] EXE_EOR = 4'b1000;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_EOR = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_ADD = 4'b0100;
    localparam logic [3:0] OP_ADC = 4'b0101;
    localparam logic [3:0] OP_SBC = 4'b0110;
    localparam logic [3:0] OP_TST = 4'b1000;
    localparam logic [3:0] OP_CMP = 4'b1010;
    localparam logic [3:0] OP_ORR = 4'b1100;
    localparam logic [3:0] OP_MOV = 4'b1101;
    localparam logic [3:0] OP_MVN = 4'b1111;

    localparam logic [1:0] MODE_ALU = 2'b00;
    localparam logic [1:0] MODE_MEM = 2'b01;
    localparam logic [1:0] MODE_BR  = 2'b10;

    typedef enum logic [3:0] {
        COND_EQ, COND_NE, COND_CS, COND_CC, COND_MI, COND_PL, COND_VS, COND_VC,
        COND_HI, COND_LS, COND_GE, COND_LT, COND_GT, COND_LE, COND_AL, COND_NV
    } cond_e;

    typedef struct packed {
        logic       s;
        logic       b;
        logic [3:0] exe_cmd;
        logic       mem_w;
        logic       mem_r;
        logic       wb_en;
    } ctrl_t;

    function automatic ctrl_t decode_ctrl(input logic [31:0] instr);
        ctrl_t c;
        c = '0;
        case (instr[27:26])
            MODE_ALU: begin
                c.s     = instr[20];
                c.wb_en = 1'b1;
                case (instr[24:21])
                    OP_MOV: c.exe_cmd = EXE_MOV;
                    OP_MVN: c.exe_cmd = EXE_MVN;
                    OP_ADD: c.exe_cmd = EXE_ADD;
                    OP_ADC: c.exe_cmd = EXE_ADC;
                    OP_SUB: c.exe_cmd = EXE_SUB;
                    OP_SBC: c.exe_cmd = EXE_SBC;
                    OP_AND: c.exe_cmd = EXE_AND;
                    OP_ORR: c.exe_cmd = EXE_ORR;
                    OP_EOR: c.exe_cmd = EXE_EOR;
                    OP_CMP: begin
                        c.exe_cmd = EXE_SUB;
                        c.wb_en   = 1'b0;
                    end
                    OP_TST: begin
                        c.exe_cmd = EXE_AND;
                        c.wb_en   = 1'b0;
                    end
                    default: begin
                        c.s     = 1'b0;
                        c.wb_en = 1'b0;
                    end
                endcase
            end
            // S selects LDR (load + write-back) versus STR; flags are never updated
            MODE_MEM: begin
                c.exe_cmd = EXE_ADD;
                c.mem_r   = instr[20];
                c.wb_en   = instr[20];
                c.mem_w   = ~instr[20];
            end
            MODE_BR: c.b = 1'b1;
            default: c = '0;
        endcase
        return c;
    endfunction

    // sr packs {V,C,Z,N}
    function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] sr);
        logic n, z, c, v, p;
        {v, c, z, n} = sr;
        case (cond_e'(cond))
            COND_EQ: p = z;
            COND_NE: p = ~z;
            COND_CS: p = c;
            COND_CC: p = ~c;
            COND_MI: p = n;
            COND_PL: p = ~n;
            COND_VS: p = v;
            COND_VC: p = ~v;
            COND_HI: p = c & ~z;
            COND_LS: p = ~c | z;
            COND_GE: p = (n == v);
            COND_LT: p = (n != v);
            COND_GT: p = ~z & (n == v);
            COND_LE: p = z | (n != v);
            COND_AL: p = 1'b1;
            default: p = 1'b0;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/decode_stage_pipe_if.sv
// rtl/decode_stage_pipe_if.sv - IF/ID inputs, write-back bus and ID/EX outputs of the decode stage
interface decode_stage_pipe_if #(
    parameter int DATA_W = 32
);
    logic [31:0]       instr_in;
    logic              instr_valid;
    logic [DATA_W-1:0] pc_in;
    logic              stall;
    logic              flush;
    logic [3:0]        sr;
    logic              wb_en;
    logic [3:0]        wb_dest;
    logic [DATA_W-1:0] wb_value;

    logic [3:0]        src1;
    logic [3:0]        src2;
    logic              two_src;

    logic              ex_valid;
    logic              ex_wb_en;
    logic              ex_mem_r_en;
    logic              ex_mem_w_en;
    logic              ex_b;
    logic              ex_s;
    logic [3:0]        ex_exe_cmd;
    logic [DATA_W-1:0] ex_val_rn;
    logic [DATA_W-1:0] ex_val_rm;
    logic              ex_imm;
    logic [11:0]       ex_shift_operand;
    logic [23:0]       ex_signed_imm_24;
    logic [3:0]        ex_dest;
    logic [DATA_W-1:0] ex_pc;

    modport master (
        output instr_in, instr_valid, pc_in, stall, flush, sr, wb_en, wb_dest, wb_value,
        input  src1, src2, two_src,
        input  ex_valid, ex_wb_en, ex_mem_r_en, ex_mem_w_en, ex_b, ex_s, ex_exe_cmd,
        input  ex_val_rn, ex_val_rm, ex_imm, ex_shift_operand, ex_signed_imm_24, ex_dest, ex_pc
    );

    modport slave (
        input  instr_in, instr_valid, pc_in, stall, flush, sr, wb_en, wb_dest, wb_value,
        output src1, src2, two_src,
        output ex_valid, ex_wb_en, ex_mem_r_en, ex_mem_w_en, ex_b, ex_s, ex_exe_cmd,
        output ex_val_rn, ex_val_rm, ex_imm, ex_shift_operand, ex_signed_imm_24, ex_dest, ex_pc
    );
endinterface

// File: rtl/regfile_2r1w.sv
// rtl/regfile_2r1w.sv - async-reset register file, 2 read / 1 write ports; ID_WB_BYPASS_EN adds write-through reads
module regfile_2r1w #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_en,
    input  logic [3:0]        wb_dest,
    input  logic [DATA_W-1:0] wb_value,
    input  logic [3:0]        rd_addr1,
    input  logic [3:0]        rd_addr2,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2
);

    logic [DATA_W-1:0] mem [NUM_REGS];

    // Indices at or above NUM_REGS match no entry, so such writes vanish
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) mem[i] <= '0;
        end else if (wb_en) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wb_dest == 4'(i)) mem[i] <= wb_value;
            end
        end
    end

    always_comb begin
        rd_data1 = '0;
        rd_data2 = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rd_addr1 == 4'(i)) rd_data1 = mem[i];
            if (rd_addr2 == 4'(i)) rd_data2 = mem[i];
        end
`ifdef ID_WB_BYPASS_EN
        if (wb_en && (wb_dest == rd_addr1) && (int'(wb_dest) < NUM_REGS)) rd_data1 = wb_value;
        if (wb_en && (wb_dest == rd_addr2) && (int'(wb_dest) < NUM_REGS)) rd_data2 = wb_value;
`endif
    end

endmodule

// File: rtl/decode_stage_pipe.sv
// rtl/decode_stage_pipe.sv - decode, condition check, register file and ID/EX register (optional ID_WB_BYPASS_EN)
module decode_stage_pipe
    import decode_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 16
) (
    input  logic              clk,
    input  logic              rst,
    decode_stage_pipe_if.slave id
);

    ctrl_t             ctrl;
    ctrl_t             ctrl_d;
    logic              live;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;

    assign id.src1    = id.instr_in[19:16];
    assign id.src2    = id.instr_in[3:0];
    assign ctrl       = decode_ctrl(id.instr_in);
    assign id.two_src = ~id.instr_in[25] | ctrl.mem_w;

    // Stall and flush both turn the slot into a bubble; upstream re-presents on stall
    assign live   = id.instr_valid & cond_pass(id.instr_in[31:28], id.sr) & ~id.stall & ~id.flush;
    assign ctrl_d = live ? ctrl : '0;

    regfile_2r1w #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS)
    ) u_regfile (
        .clk      (clk),
        .rst      (rst),
        .wb_en    (id.wb_en),
        .wb_dest  (id.wb_dest),
        .wb_value (id.wb_value),
        .rd_addr1 (id.src1),
        .rd_addr2 (id.src2),
        .rd_data1 (rd1),
        .rd_data2 (rd2)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id.ex_valid         <= 1'b0;
            id.ex_wb_en         <= 1'b0;
            id.ex_mem_r_en      <= 1'b0;
            id.ex_mem_w_en      <= 1'b0;
            id.ex_b             <= 1'b0;
            id.ex_s             <= 1'b0;
            id.ex_exe_cmd       <= '0;
            id.ex_val_rn        <= '0;
            id.ex_val_rm        <= '0;
            id.ex_imm           <= 1'b0;
            id.ex_shift_operand <= '0;
            id.ex_signed_imm_24 <= '0;
            id.ex_dest          <= '0;
            id.ex_pc            <= '0;
        end else begin
            id.ex_valid         <= live;
            id.ex_wb_en         <= ctrl_d.wb_en;
            id.ex_mem_r_en      <= ctrl_d.mem_r;
            id.ex_mem_w_en      <= ctrl_d.mem_w;
            id.ex_b             <= ctrl_d.b;
            id.ex_s             <= ctrl_d.s;
            id.ex_exe_cmd       <= ctrl_d.exe_cmd;
            id.ex_val_rn        <= rd1;
            id.ex_val_rm        <= rd2;
            id.ex_imm           <= id.instr_in[25];
            id.ex_shift_operand <= id.instr_in[11:0];
            id.ex_signed_imm_24 <= id.instr_in[23:0];
            id.ex_dest          <= id.instr_in[15:12];
            id.ex_pc            <= id.pc_in;
        end
    end

endmodule

// File: tb/tb_decode_stage_pipe.sv
// tb/tb_decode_stage_pipe.sv - scoreboard bench for decode_stage_pipe with directed vectors
module tb_decode_stage_pipe;

    localparam int DATA_W = 32;
    localparam logic [3:0] AL = 4'hE;

    typedef struct packed {
        logic        valid;
        logic        wb;
        logic        mr;
        logic        mw;
        logic        b;
        logic        s;
        logic [3:0]  cmd;
        logic [3:0]  dest;
        logic [31:0] rn;
        logic [31:0] rm;
        logic [31:0] pc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    exp_t q[$];
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    decode_stage_pipe_if #(.DATA_W(DATA_W)) bus ();

    decode_stage_pipe #(.DATA_W(DATA_W), .NUM_REGS(16)) dut (
        .clk (clk),
        .rst (rst),
        .id  (bus)
    );

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endfunction

    function automatic logic [31:0] ins(input logic [3:0] cond, input logic [1:0] mode, input logic imm,
                                        input logic [3:0] op, input logic s, input logic [3:0] rn,
                                        input logic [3:0] rd, input logic [11:0] op2);
        return {cond, mode, imm, op, s, rn, rd, op2};
    endfunction

    function automatic exp_t bub();
        exp_t e;
        e = '0;
        return e;
    endfunction

    function automatic exp_t lv(input logic wb, input logic mr, input logic mw, input logic b, input logic s,
                                input logic [3:0] cmd, input logic [3:0] dest,
                                input logic [31:0] rn, input logic [31:0] rm, input logic [31:0] pc);
        exp_t e;
        e.valid = 1'b1; e.wb = wb; e.mr = mr; e.mw = mw; e.b = b; e.s = s;
        e.cmd = cmd; e.dest = dest; e.rn = rn; e.rm = rm; e.pc = pc;
        return e;
    endfunction

    task automatic step(input logic [31:0] iw, input logic v, input logic [31:0] pc,
                        input logic st, input logic fl, input logic [3:0] s_r,
                        input logic we, input logic [3:0] wd, input logic [31:0] wv, input exp_t e);
        @(posedge clk);
        #2;
        bus.instr_in    = iw;
        bus.instr_valid = v;
        bus.pc_in       = pc;
        bus.stall       = st;
        bus.flush       = fl;
        bus.sr          = s_r;
        bus.wb_en       = we;
        bus.wb_dest     = wd;
        bus.wb_value    = wv;
        q.push_back(e);
    endtask

    // Monitor: each edge's capture is compared against the oldest queued expectation
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("ex_valid",    32'(bus.ex_valid),    32'(e.valid));
                chk("ex_wb_en",    32'(bus.ex_wb_en),    32'(e.wb));
                chk("ex_mem_r_en", 32'(bus.ex_mem_r_en), 32'(e.mr));
                chk("ex_mem_w_en", 32'(bus.ex_mem_w_en), 32'(e.mw));
                chk("ex_b",        32'(bus.ex_b),        32'(e.b));
                chk("ex_s",        32'(bus.ex_s),        32'(e.s));
                chk("ex_exe_cmd",  32'(bus.ex_exe_cmd),  32'(e.cmd));
                if (e.valid) begin
                    chk("ex_val_rn", bus.ex_val_rn,    e.rn);
                    chk("ex_val_rm", bus.ex_val_rm,    e.rm);
                    chk("ex_dest",   32'(bus.ex_dest), 32'(e.dest));
                    chk("ex_pc",     bus.ex_pc,        e.pc);
                end
            end
        end
    end

    initial begin
        logic [31:0] byp_val;
`ifdef ID_WB_BYPASS_EN
        byp_val = 32'hCAFEF00D;
`else
        byp_val = 32'h0;
`endif
        bus.instr_in = '0; bus.instr_valid = 1'b0; bus.pc_in = '0; bus.stall = 1'b0;
        bus.flush = 1'b0; bus.sr = 4'h0; bus.wb_en = 1'b0; bus.wb_dest = 4'h0; bus.wb_value = '0;
        #1;
        chk("reset_ex_valid", 32'(bus.ex_valid), 32'h0);
        chk("reset_ex_pc",    bus.ex_pc,         32'h0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;

        // Preload R3, read it back, then reset asynchronously mid-cycle
        step(32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 1'b1, 4'd3, 32'hDEADBEEF, bub());
        step(ins(AL, 2'b00, 1'b0, 4'b0100, 1'b0, 4'd3, 4'd4, 12'h003), 1'b1, 32'h40, 1'b0, 1'b0, 4'h0,
             1'b0, 4'd0, 32'h0, lv(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0010, 4'd4, 32'hDEADBEEF, 32'hDEADBEEF, 32'h40));
        @(posedge clk);
        #3;
        bus.instr_valid = 1'b0;
        bus.wb_en = 1'b1; bus.wb_dest = 4'd5; bus.wb_value = 32'h00005555;
        rst = 1'b1;
        #1;
        chk("async_rst_ex_valid",   32'(bus.ex_valid),   32'h0);
        chk("async_rst_ex_wb_en",   32'(bus.ex_wb_en),   32'h0);
        chk("async_rst_ex_exe_cmd", 32'(bus.ex_exe_cmd), 32'h0);
        chk("async_rst_ex_val_rn",  bus.ex_val_rn,       32'h0);
        chk("async_rst_ex_pc",      bus.ex_pc,           32'h0);
        chk("async_rst_ex_dest",    32'(bus.ex_dest),    32'h0);
        repeat (2) @(posedge clk);
        #2;
        bus.wb_en = 1'b0;
        rst = 1'b0;

        // R3 cleared by reset; write-back to R5 during reset was dropped
        step(ins(AL, 2'b00, 1'b0, 4'b0100, 1'b0, 4'd3, 4'd1, 12'h005), 1'b1, 32'h80, 1'b0, 1'b0, 4'h0,
             1'b0, 4'd0, 32'h0, lv(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0010, 4'd1, 32'h0, 32'h0, 32'h80));
        step(ins(AL, 2'b00, 1'b0, 4'b0100, 1'b0, 4'd2, 4'd1, 12'h002), 1'b0, 32'h84, 1'b0, 1'b0, 4'h0,
             1'b1, 4'd2, 32'h12345678, bub());
        step(ins(AL, 2'b00, 1'b0, 4'b0100, 1'b0, 4'd2, 4'd1, 12'h002), 1'b1, 32'h84, 1'b0, 1'b0, 4'h0,
             1'b0, 4'd0, 32'h0, lv(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0010, 4'd1, 32'h12345678, 32'h12345678, 32'h84));
        #1;
        chk("src1",    32'(bus.src1),    32'd2);
        chk("src2",    32'(bus.src2),    32'd2);
        chk("two_src", 32'(bus.two_src), 32'd1);

        // Write-back and dependent decode in the same cycle, both ports hit
        step(ins(AL, 2'b00, 1'b0, 4'b0100, 1'b0, 4'd6, 4'd7, 12'h006), 1'b1, 32'h88, 1'b0, 1'b0, 4'h0,
             1'b1, 4'd6, 32'hCAFEF00D, lv(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0010, 4'd7, byp_val, byp_val, 32'h88));

        // MOVEQ: fails with Z=0, passes with Z=1
        step(ins(4'h0, 2'b00, 1'b1, 4'b1101, 1'b0, 4'd0, 4'd8, 12'h005), 1'b1, 32'h8C, 1'b0, 1'b0, 4'b0000,
             1'b0, 4'd0, 32'h0, bub());
        #1;
        chk("two_src_imm", 32'(bus.two_src), 32'd0);
        step(ins(4'h0, 2'b00, 1'b1, 4'b1101, 1'b0, 4'd0, 4'd8, 12'h005), 1'b1, 32'h90, 1'b0, 1'b0, 4'b0010,
             1'b0, 4'd0, 32'h0, lv(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0001, 4'd8, 32'h0, 32'h0, 32'h90));

        // Back to back: live, stall, flush, then stall+flush together
        step(ins(AL, 2'b00, 1'b0, 4'b0010, 1'b0, 4'd6, 4'd1, 12'h006), 1'b1, 32'h94, 1'b0, 1'b0, 4'h0,
             1'b0, 4'd0, 32'h0, lv(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0100, 4'd1, 32'hCAFEF00D, 32'hCAFEF00D, 32'h94));
        step(ins(AL, 2'b00, 1'b0, 4'b1100, 1'b1, 4'd6, 4'd1, 12'h006), 1'b1, 32'h98, 1'b1, 1'b0, 4'h0,
             1'b0, 4'd0, 32'h0, bub());
        step(ins(AL, 2'b00, 1'b0, 4'b0001, 1'b1, 4'd6, 4'd1, 12'h006), 1'b1, 32'h9C, 1'b0, 1'b1, 4'h0,
             1'b0, 4'd0, 32'h0, bub());
        step(ins(AL, 2'b00, 1'b0, 4'b0100, 1'b1, 4'd6, 4'd1, 12'h006), 1'b1, 32'h9C, 1'b1, 1'b1, 4'h0,
             1'b0, 4'd0, 32'h0, bub());

        // LDR and STR
        step(ins(AL, 2'b01, 1'b0, 4'b1100, 1'b1, 4'd6, 4'd9, 12'h004), 1'b1, 32'hA0, 1'b0, 1'b0, 4'h0,
             1'b0, 4'd0, 32'h0, lv(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0010, 4'd9, 32'hCAFEF00D, 32'h0, 32'hA0));
        step(ins(AL, 2'b01, 1'b1, 4'b1100, 1'b0, 4'd6, 4'd2, 12'h003), 1'b1, 32'hA4, 1'b0, 1'b0, 4'h0,
             1'b0, 4'd0, 32'h0, lv(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0010, 4'd2, 32'hCAFEF00D, 32'h0, 32'hA4));
        #1;
        chk("two_src_str_imm", 32'(bus.two_src), 32'd1);

        // CMPS, branch, never-condition
        step(ins(AL, 2'b00, 1'b0, 4'b1010, 1'b1, 4'd6, 4'd0, 12'h002), 1'b1, 32'hA8, 1'b0, 1'b0, 4'h0,
             1'b0, 4'd0, 32'h0, lv(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0100, 4'd0, 32'hCAFEF00D, 32'h12345678, 32'hA8));
        step(32'hEAFFFFFE, 1'b1, 32'hAC, 1'b0, 1'b0, 4'h0,
             1'b0, 4'd0, 32'h0, lv(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 4'hF, 32'h0, 32'h0, 32'hAC));
        step(ins(4'hF, 2'b00, 1'b0, 4'b0100, 1'b0, 4'd6, 4'd1, 12'h006), 1'b1, 32'hB0, 1'b0, 1'b0, 4'h0,
             1'b0, 4'd0, 32'h0, bub());
        step(32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 1'b0, 4'd0, 32'h0, bub());

        repeat (3) @(posedge clk);
        #2;
        chk("scoreboard_drained", 32'(q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
